// File: rtl/time_counter.sv
// time_counter: BCD hh:mm:ss time-of-day counter driven by rising edges of a
// 1 Hz pulse, with synchronous time load and carry pulses.
// Optional feature: define CLK_TIME_12H_EN to present hh as a 12-hour value
// with a PM flag (the internal count stays 24-hour).
module time_counter #(
  parameter logic [7:0] RESET_HH = 8'h00,
  parameter logic [7:0] RESET_MM = 8'h00,
  parameter logic [7:0] RESET_SS = 8'h00
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       clk_1hz,
  input  logic       run,
  input  logic       set_valid,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       tick_1s,
  output logic       min_tick,
  output logic       hour_tick,
  output logic       day_wrap,
  output logic       set_err
);

  logic [7:0] hh_q, hh_d;
  logic [7:0] mm_q, mm_d;
  logic [7:0] ss_q, ss_d;
  logic       clk_1hz_q;
  logic       tick_q, tick_d;
  logic       min_q, min_d;
  logic       hour_q, hour_d;
  logic       day_q, day_d;
  logic       err_q, err_d;
  logic       edge_c;
  logic       set_ok_c;

  // Increment a BCD 00..59 value, wrapping 59 -> 00.
  function automatic logic [7:0] inc_bcd60(input logic [7:0] v);
    logic [7:0] r;
    if (v[3:0] == 4'd9) begin
      if (v[7:4] == 4'd5) r = 8'h00;
      else                r = {4'(v[7:4] + 4'd1), 4'd0};
    end else begin
      r = {v[7:4], 4'(v[3:0] + 4'd1)};
    end
    return r;
  endfunction

  // Increment a BCD 00..23 hour, wrapping 23 -> 00.
  function automatic logic [7:0] inc_bcd24(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h23)            r = 8'h00;
    else if (v[3:0] == 4'd9)   r = {4'(v[7:4] + 4'd1), 4'd0};
    else                       r = {v[7:4], 4'(v[3:0] + 4'd1)};
    return r;
  endfunction

  assign edge_c   = clk_1hz & ~clk_1hz_q;
  assign set_ok_c = (set_hh[3:0] <= 4'd9) && (set_hh[7:4] <= 4'd9) && (set_hh <= 8'h23) &&
                    (set_mm[3:0] <= 4'd9) && (set_mm[7:4] <= 4'd9) && (set_mm <= 8'h59) &&
                    (set_ss[3:0] <= 4'd9) && (set_ss[7:4] <= 4'd9) && (set_ss <= 8'h59);

  // Next-state: set has priority over a coincident tick; ticks only when running.
  always_comb begin
    hh_d   = hh_q;
    mm_d   = mm_q;
    ss_d   = ss_q;
    tick_d = 1'b0;
    min_d  = 1'b0;
    hour_d = 1'b0;
    day_d  = 1'b0;
    err_d  = 1'b0;
    if (set_valid) begin
      if (set_ok_c) begin
        hh_d = set_hh;
        mm_d = set_mm;
        ss_d = set_ss;
      end else begin
        err_d = 1'b1;
      end
    end else if (edge_c && run) begin
      tick_d = 1'b1;
      ss_d   = inc_bcd60(ss_q);
      if (ss_q == 8'h59) begin
        min_d = 1'b1;
        mm_d  = inc_bcd60(mm_q);
        if (mm_q == 8'h59) begin
          hour_d = 1'b1;
          hh_d   = inc_bcd24(hh_q);
          day_d  = (hh_q == 8'h23);
        end
      end
    end
  end

  // State and pulse registers; edge history is preset high so a held-high
  // clk_1hz at reset release does not produce a tick.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      hh_q      <= RESET_HH;
      mm_q      <= RESET_MM;
      ss_q      <= RESET_SS;
      clk_1hz_q <= 1'b1;
      tick_q    <= 1'b0;
      min_q     <= 1'b0;
      hour_q    <= 1'b0;
      day_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      hh_q      <= hh_d;
      mm_q      <= mm_d;
      ss_q      <= ss_d;
      clk_1hz_q <= clk_1hz;
      tick_q    <= tick_d;
      min_q     <= min_d;
      hour_q    <= hour_d;
      day_q     <= day_d;
      err_q     <= err_d;
    end
  end

  assign mm        = mm_q;
  assign ss        = ss_q;
  assign tick_1s   = tick_q;
  assign min_tick  = min_q;
  assign hour_tick = hour_q;
  assign day_wrap  = day_q;
  assign set_err   = err_q;

`ifdef CLK_TIME_12H_EN
  logic [4:0] h_bin_c;
  logic [4:0] h12_c;
  logic       pm_c;

  // 24h -> 12h display conversion from the registered hour.
  always_comb begin
    h_bin_c = 5'(hh_q[7:4]) * 5'd10 + 5'(hh_q[3:0]);
    h12_c   = h_bin_c;
    pm_c    = 1'b0;
    if (h_bin_c == 5'd0) begin
      h12_c = 5'd12;
    end else if (h_bin_c == 5'd12) begin
      pm_c = 1'b1;
    end else if (h_bin_c > 5'd12) begin
      h12_c = 5'(h_bin_c - 5'd12);
      pm_c  = 1'b1;
    end
  end

  assign hh = (h12_c >= 5'd10) ? {4'd1, 4'(h12_c - 5'd10)} : {4'd0, 4'(h12_c)};
  assign pm = pm_c;
`else
  assign hh = hh_q;
  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter: directed scenarios then randomized traffic, each
// cycle checked against a seconds-of-day reference model.
module tb_time_counter;

  logic       clk_in = 1'b0;
  logic       rst = 1'b1;
  logic       clk_1hz = 1'b1;
  logic       run = 1'b0;
  logic       set_valid = 1'b0;
  logic [7:0] set_hh = 8'h00;
  logic [7:0] set_mm = 8'h00;
  logic [7:0] set_ss = 8'h00;
  logic [7:0] hh, mm, ss;
  logic       pm, tick_1s, min_tick, hour_tick, day_wrap, set_err;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_secs = 0;
  bit m_prev = 1'b1;
  bit m_tick, m_min, m_hour, m_day, m_err;

  time_counter #(.RESET_HH(8'h00), .RESET_MM(8'h00), .RESET_SS(8'h00)) dut (
    .clk_in(clk_in), .rst(rst), .clk_1hz(clk_1hz), .run(run),
    .set_valid(set_valid), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .hh(hh), .mm(mm), .ss(ss), .pm(pm), .tick_1s(tick_1s), .min_tick(min_tick),
    .hour_tick(hour_tick), .day_wrap(day_wrap), .set_err(set_err)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  function automatic int from_bcd(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [7:0] b, input int maxv);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9) && (from_bcd(b) <= maxv);
  endfunction

  function automatic logic [29:0] expected();
    int h, hd;
    bit p;
    h  = m_secs / 3600;
    hd = h;
    p  = 1'b0;
`ifdef CLK_TIME_12H_EN
    p  = (h >= 12);
    hd = (h % 12 == 0) ? 12 : h % 12;
`endif
    return {to_bcd(hd), to_bcd((m_secs / 60) % 60), to_bcd(m_secs % 60), p,
            m_tick, m_min, m_hour, m_day, m_err};
  endfunction

  // One clock: drive inputs, advance model on the edge, compare all outputs.
  task automatic step(input logic r, input logic p, input logic rn, input logic sv,
                      input logic [7:0] sh, input logic [7:0] sm, input logic [7:0] s,
                      input string tag);
    bit e;
    logic [29:0] got, exp_v;
    rst = r; clk_1hz = p; run = rn; set_valid = sv;
    set_hh = sh; set_mm = sm; set_ss = s;
    @(posedge clk_in);
    {m_tick, m_min, m_hour, m_day, m_err} = '0;
    if (r) begin
      m_secs = 0;
      m_prev = 1'b1;
    end else begin
      e = p && !m_prev;
      m_prev = p;
      if (sv) begin
        if (bcd_ok(sh, 23) && bcd_ok(sm, 59) && bcd_ok(s, 59))
          m_secs = from_bcd(sh) * 3600 + from_bcd(sm) * 60 + from_bcd(s);
        else
          m_err = 1'b1;
      end else if (e && rn) begin
        m_secs = (m_secs + 1) % 86400;
        m_tick = 1'b1;
        m_min  = (m_secs % 60 == 0);
        m_hour = (m_secs % 3600 == 0);
        m_day  = (m_secs == 0);
      end
    end
    #1;
    got   = {hh, mm, ss, pm, tick_1s, min_tick, hour_tick, day_wrap, set_err};
    exp_v = expected();
    checks++;
    assert (got === exp_v) else begin
      errors++;
      $error("FAIL %s: got hh:mm:ss=%h:%h:%h pm/tk/mn/hr/dy/er=%b expected %h:%h:%h %b",
             tag, got[29:22], got[21:14], got[13:6], got[5:0],
             exp_v[29:22], exp_v[21:14], exp_v[13:6], exp_v[5:0]);
    end
  endtask

  task automatic idle(input logic p, input logic rn, input string tag);
    step(1'b0, p, rn, 1'b0, 8'h00, 8'h00, 8'h00, tag);
  endtask

  task automatic pulse(input logic rn, input string tag);
    idle(1'b0, rn, tag);
    idle(1'b1, rn, tag);
    idle(1'b1, rn, tag);
  endtask

  task automatic set_time(input logic [7:0] sh, input logic [7:0] sm, input logic [7:0] s,
                          input string tag);
    step(1'b0, 1'b1, 1'b1, 1'b1, sh, sm, s, tag);
    idle(1'b1, 1'b1, tag);
  endtask

  initial begin
    logic p, r, rn, sv;
    logic [7:0] sh, sm, s;

    // Reset with clk_1hz held high, then no tick while it stays high
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, "reset");
    for (int i = 0; i < 5; i++) idle(1'b1, 1'b1, "post_reset");

    // Three counted edges
    for (int i = 0; i < 3; i++) pulse(1'b1, "count3");

    // Day wrap at 23:59:59
    set_time(8'h23, 8'h59, 8'h58, "set_2359");
    pulse(1'b1, "to_235959");
    pulse(1'b1, "day_wrap");

    // Rejected sets leave time unchanged
    set_time(8'h24, 8'h00, 8'h00, "bad_hour");
    set_time(8'h12, 8'h6A, 8'h00, "bad_min_digit");
    set_time(8'h00, 8'h60, 8'h00, "bad_min");
    set_time(8'h00, 8'h00, 8'h5A, "bad_sec_digit");

    // Set coincident with an edge drops the tick
    idle(1'b0, 1'b1, "pre_coincide");
    step(1'b0, 1'b1, 1'b1, 1'b1, 8'h10, 8'h00, 8'h00, "set_with_edge");
    idle(1'b1, 1'b1, "after_set");
    pulse(1'b1, "tick_after_set");

    // Hold while stopped; set still accepted
    for (int i = 0; i < 4; i++) pulse(1'b0, "run0_hold");
    step(1'b0, 1'b1, 1'b0, 1'b1, 8'h13, 8'h05, 8'h00, "set_run0");
    idle(1'b1, 1'b0, "pm_hour");
    set_time(8'h00, 8'h00, 8'h00, "midnight");
    set_time(8'h12, 8'h00, 8'h00, "noon");
    set_time(8'h09, 8'h59, 8'h59, "pre_hour");
    pulse(1'b1, "hour_tick");

    // Reset overrides a coincident set and edge
    idle(1'b0, 1'b1, "pre_rst");
    step(1'b1, 1'b1, 1'b1, 1'b1, 8'h05, 8'h05, 8'h05, "rst_override");

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      p  = ($urandom_range(0, 2) != 0) ? clk_1hz : ~clk_1hz;
      rn = ($urandom_range(0, 7) != 0);
      sv = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) begin
        sh = 8'($urandom); sm = 8'($urandom); s = 8'($urandom);
      end else begin
        sh = to_bcd($urandom_range(21, 23));
        sm = to_bcd($urandom_range(57, 59));
        s  = to_bcd($urandom_range(50, 59));
      end
      step(r, p, rn, sv, sh, sm, s, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
